// File: rtl/handshake_tx_arbiter_pkg.sv
// Shared definitions for the round-robin front end of the handshake transmitter:
// FSM state encodings and the helper that locates one source's payload slice.
package handshake_tx_arbiter_pkg;

  // One-hot so that every state is a single flop and a bad state is easy to spot.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_BUSY  = 4'b0100,
    ST_WAIT  = 4'b1000
  } arbState_e;

  // Low bit of source idx's payload inside the packed per-source data bus.
  function automatic int unsigned sliceLo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/handshake_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first requester at or after the
// pointer, wrapping around, and reports it as one-hot, as an index and as a flag.
module handshake_tx_arbiter_rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SW-1:0]      ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [SW-1:0]      idx_o,
  output logic               any_o
);

  int cand;

  // Scan from the farthest offset back to the pointer so the nearest requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = (int'(ptr_i) + i) % NUM_SRC;
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = SW'(cand);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_tx_arbiter.sv
// Shares one four-phase handshake TX channel between NUM_SRC requesters.
// Issues a one-cycle request pulse with the winner's payload, then follows the
// transmitter's idle flag through the handshake, flagging a stalled receiver.
module handshake_tx_arbiter
  import handshake_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DW      = 32,
  parameter int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    src_req_i,
  input  logic [NUM_SRC*DW-1:0] src_data_i,
  output logic [NUM_SRC-1:0]    src_ack_o,
  input  logic                  tx_idle_i,
  output logic                  tx_req_o,
  output logic [DW-1:0]         tx_req_data_o,
  output logic [SW-1:0]         gnt_id_o,
  output logic                  busy_o,
  input  logic                  clr_timeout_i,
  output logic                  timeout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  arbState_e          state_q;
  logic [SW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               txReq_q;
  logic [DW-1:0]      txData_q;
  logic [NUM_SRC-1:0] ack_q;
  logic [SW-1:0]      gnt_q;
  logic               busy_q;
  logic               timeout_q;

  logic [NUM_SRC-1:0] pickGnt;
  logic [SW-1:0]      pickIdx;
  logic               pickAny;
  logic [DW-1:0]      pickData;
  logic               inHold;
  logic               timeoutSet;

  handshake_tx_arbiter_rr_pick #(
    .NUM_SRC(NUM_SRC),
    .SW     (SW)
  ) u_rr_pick (
    .req_i(src_req_i),
    .ptr_i(ptr_q),
    .gnt_o(pickGnt),
    .idx_o(pickIdx),
    .any_o(pickAny)
  );

  // Next pointer, winner payload and the saturating stall counter with its set pulse.
  always_comb begin
    ptr_d = (pickIdx == SW'(NUM_SRC - 1)) ? '0 : pickIdx + SW'(1);

    pickData = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pickIdx == SW'(k)) begin
        pickData = src_data_i[sliceLo(k, DW) +: DW];
      end
    end

    inHold = (state_q == ST_BUSY) || (state_q == ST_WAIT);
    if (!inHold) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Gated by the flag itself so a clear during a persistent stall takes effect
    // for one cycle before the flag is raised again.
    timeoutSet = (TIMEOUT != 0) && inHold && (cnt_d == CNT_MAX) && !timeout_q;
  end

  // Arbitration FSM with every output held in a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      txReq_q   <= 1'b0;
      txData_q  <= '0;
      ack_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (timeoutSet) begin
        timeout_q <= 1'b1;
      end else if (clr_timeout_i) begin
        timeout_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (tx_idle_i && pickAny) begin
            txReq_q  <= 1'b1;
            txData_q <= pickData;
            ack_q    <= pickGnt;
            gnt_q    <= pickIdx;
            ptr_q    <= ptr_d;
            busy_q   <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          txReq_q  <= 1'b0;
          txData_q <= '0;
          ack_q    <= '0;
          state_q  <= ST_BUSY;
        end
        ST_BUSY: begin
          if (!tx_idle_i) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tx_idle_i) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          txReq_q  <= 1'b0;
          txData_q <= '0;
          ack_q    <= '0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_req_o      = txReq_q;
  assign tx_req_data_o = txData_q;
  assign src_ack_o     = ack_q;
  assign gnt_id_o      = gnt_q;
  assign busy_o        = busy_q;
  assign timeout_o     = timeout_q;

endmodule
